// File: rtl/vga_pkg.sv
// Shared VGA framebuffer constants, sprite indices and FSM encoding for the
// tile plotting path.
package vga_pkg;
  localparam int VGA_SCREEN_W = 160;
  localparam int VGA_SCREEN_H = 120;
  localparam int VGA_COLOR_W  = 3;

  typedef enum logic [1:0] {EMPTY = 2'd0, SELECT = 2'd1, BLACK = 2'd2, WHITE = 2'd3} sprite_e;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} plot_state_e;

  // Bits needed to index v items; never below 1 so tiny tiles still get a port.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/tile_scan_counter.sv
// Column-major dx/dy walker over a TILE x TILE window with a running linear
// index (dx*TILE+dy), built purely from increments.
module tile_scan_counter import vga_pkg::*; #(
  parameter int TILE = 12,
  parameter int CW   = clog2(TILE),
  parameter int AW   = clog2(TILE*TILE)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          en,
  output logic [CW-1:0] dx,
  output logic [CW-1:0] dy,
  output logic [AW-1:0] idx,
  output logic          last
);
  localparam logic [CW-1:0] EDGE = CW'(TILE-1);

  assign last = (dx == EDGE) && (dy == EDGE);

  // Wraps to zero after the final pixel so the next tile starts clean.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dx  <= '0;
      dy  <= '0;
      idx <= '0;
    end else if (en) begin
      if (last) begin
        dx  <= '0;
        dy  <= '0;
        idx <= '0;
      end else begin
        idx <= idx + 1'b1;
        if (dy == EDGE) begin
          dy <= '0;
          dx <= dx + 1'b1;
        end else begin
          dy <= dy + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/tile_plotter.sv
// Sprite/tile blitter: walks a TILE x TILE window, fetches colours from an
// external sprite ROM and streams clipped, optionally corner-masked pixels.
module tile_plotter import vga_pkg::*; #(
  parameter int TILE     = 12,
  parameter int SEL_W    = 2,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = VGA_COLOR_W,
  parameter int SCREEN_W = VGA_SCREEN_W,
  parameter int SCREEN_H = VGA_SCREEN_H,
  parameter int ROM_LAT  = 1
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [X_W-1:0]                x_in,
  input  logic [Y_W-1:0]                y_in,
  input  logic [SEL_W-1:0]              select,
  input  logic                          mask_corners,
  output logic                          busy,
  output logic                          done,
  output logic [clog2(TILE*TILE)-1:0]   rom_addr,
  output logic [SEL_W-1:0]              rom_sel,
  input  logic [COLOR_W-1:0]            rom_data,
  output logic                          plot,
  output logic [X_W-1:0]                x_out,
  output logic [Y_W-1:0]                y_out,
  output logic [COLOR_W-1:0]            color
);
  localparam int AW = clog2(TILE*TILE);
  localparam int CW = clog2(TILE);
  localparam int OS = ROM_LAT - 1;
  localparam logic [CW-1:0] EDGE = CW'(TILE-1);

  plot_state_e    state;
  logic [X_W-1:0] x_lat;
  logic [Y_W-1:0] y_lat;
  logic           mask_lat;
  logic [1:0]     dcnt;

  logic [CW-1:0]  dx, dy;
  logic [AW-1:0]  idx;
  logic           last;
  logic           issue;

  // Stage 0 travels with rom_addr; stage ROM_LAT-1 meets its rom_data.
  logic [ROM_LAT-1:0]         vld_pipe;
  logic [ROM_LAT-1:0][CW-1:0] dx_pipe;
  logic [ROM_LAT-1:0][CW-1:0] dy_pipe;

  assign issue = ((state == IDLE) && start) || (state == SCAN);

  tile_scan_counter #(.TILE(TILE), .CW(CW), .AW(AW)) u_scan (
    .clock (clock),
    .resetn(resetn),
    .en    (issue),
    .dx    (dx),
    .dy    (dy),
    .idx   (idx),
    .last  (last)
  );

  // Extra bit keeps off-screen coordinates from aliasing back on screen.
  logic [X_W:0] xs;
  logic [Y_W:0] ys;
  logic         corner, on_screen;

  assign xs        = {1'b0, x_lat} + (X_W+1)'(dx_pipe[OS]);
  assign ys        = {1'b0, y_lat} + (Y_W+1)'(dy_pipe[OS]);
  assign corner    = mask_lat && (dx_pipe[OS] == '0 || dx_pipe[OS] == EDGE)
                              && (dy_pipe[OS] == '0 || dy_pipe[OS] == EDGE);
  assign on_screen = (xs < (X_W+1)'(SCREEN_W)) && (ys < (Y_W+1)'(SCREEN_H));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      x_lat    <= '0;
      y_lat    <= '0;
      mask_lat <= 1'b0;
      rom_sel  <= '0;
      rom_addr <= '0;
      dcnt     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      vld_pipe <= '0;
      dx_pipe  <= '0;
      dy_pipe  <= '0;
      plot     <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      color    <= '0;
    end else begin
      vld_pipe[0] <= issue;
      dx_pipe[0]  <= dx;
      dy_pipe[0]  <= dy;
      if (issue) rom_addr <= idx;
      for (int i = ROM_LAT-1; i > 0; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dx_pipe[i]  <= dx_pipe[i-1];
        dy_pipe[i]  <= dy_pipe[i-1];
      end

      // Every slot updates the output so timing ignores masking and clipping.
      plot <= vld_pipe[OS] && !corner && on_screen;
      if (vld_pipe[OS]) begin
        x_out <= xs[X_W-1:0];
        y_out <= ys[Y_W-1:0];
        color <= rom_data;
      end

      case (state)
        IDLE: if (start) begin
          x_lat    <= x_in;
          y_lat    <= y_in;
          rom_sel  <= select;
          mask_lat <= mask_corners;
          busy     <= 1'b1;
          state    <= SCAN;
        end
        SCAN: if (last) begin
          dcnt  <= '0;
          state <= DRAIN;
        end
        DRAIN: if (dcnt == 2'(ROM_LAT)) begin
          done  <= 1'b1;
          state <= DONE;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_plotter.sv
// Directed bench for tile_plotter: a 12x12/ROM_LAT=1 instance and a
// 6x6/ROM_LAT=3 instance, both fed by sprite ROM models returning addr[2:0].
module tb_tile_plotter;
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // 12x12, ROM_LAT=1: ROM is a combinational read of rom_addr.
  logic       start, mask_corners, busy, done, plot;
  logic [7:0] x_in, x_out, rom_addr;
  logic [6:0] y_in, y_out;
  logic [1:0] select, rom_sel;
  logic [2:0] rom_data, color;
  assign rom_data = rom_addr[2:0];

  tile_plotter #(.TILE(12), .ROM_LAT(1)) dut_a (
    .clock(clock), .resetn(resetn), .start(start), .x_in(x_in), .y_in(y_in),
    .select(select), .mask_corners(mask_corners), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_data(rom_data), .plot(plot),
    .x_out(x_out), .y_out(y_out), .color(color)
  );

  // 6x6, ROM_LAT=3: two register stages in front of the ROM contents.
  logic       b_start, b_busy, b_done, b_plot;
  logic [7:0] b_x_out;
  logic [6:0] b_y_out;
  logic [1:0] b_rom_sel;
  logic [5:0] b_rom_addr, b_d1, b_d2;
  logic [2:0] b_rom_data, b_color;
  always @(posedge clock) begin
    b_d1 <= b_rom_addr;
    b_d2 <= b_d1;
  end
  assign b_rom_data = b_d2[2:0];

  tile_plotter #(.TILE(6), .ROM_LAT(3)) dut_b (
    .clock(clock), .resetn(resetn), .start(b_start), .x_in(8'd30), .y_in(7'd40),
    .select(2'd1), .mask_corners(1'b0), .busy(b_busy), .done(b_done),
    .rom_addr(b_rom_addr), .rom_sel(b_rom_sel), .rom_data(b_rom_data), .plot(b_plot),
    .x_out(b_x_out), .y_out(b_y_out), .color(b_color)
  );

  int n_vec = 0, n_miss = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int  k, n_plot, n_done, col_err, clip_err, corner_err, anc_err;
  int  first_cyc, done_cyc, fx, fy, sx, sy, lx, ly, cur_x, cur_y;
  bit  cur_mask;

  task automatic go_a(input int x, input int y, input int sel, input bit m);
    @(negedge clock);
    x_in = 8'(x); y_in = 7'(y); select = 2'(sel); mask_corners = m;
    cur_x = x; cur_y = y; cur_mask = m;
    start = 1'b1;
    k = cyc + 1;
  endtask

  // Observes one or more tiles; cycle numbers are those of the sampling edge.
  task automatic watch_a(input int budget, input int want_done, input bit hold, input int poke_at);
    int dxi, dyi;
    n_plot = 0; n_done = 0; col_err = 0; clip_err = 0; corner_err = 0; anc_err = 0;
    first_cyc = -1; done_cyc = -1;
    for (int i = 0; i < budget && n_done < want_done; i++) begin
      @(negedge clock);
      if (!hold) start = 1'b0;
      if (i == poke_at) x_in = 8'd99;
      if (plot) begin
        n_plot++;
        if (n_plot == 1) begin first_cyc = cyc + 1; fx = int'(x_out); fy = int'(y_out); end
        if (n_plot == 2) begin sx = int'(x_out); sy = int'(y_out); end
        lx = int'(x_out); ly = int'(y_out);
        dxi = int'(x_out) - cur_x;
        dyi = int'(y_out) - cur_y;
        if (dxi < 0 || dxi > 11 || dyi < 0 || dyi > 11) anc_err++;
        else if (int'(color) != (dxi*12 + dyi) % 8) col_err++;
        if (x_out >= 8'd160 || y_out >= 7'd120) clip_err++;
        if (cur_mask && (dxi == 0 || dxi == 11) && (dyi == 0 || dyi == 11)) corner_err++;
      end
      if (done) begin
        n_done++;
        if (n_done == 1) done_cyc = cyc + 1;
        cur_x = int'(x_in); cur_y = int'(y_in);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int kb, bn, bfirst, bdone, bcol, bfx, bfy, blx, bly, idx;
    resetn = 1'b0; start = 1'b0; b_start = 1'b0;
    x_in = '0; y_in = '0; select = '0; mask_corners = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_xy", int'(x_out) + int'(y_out) + int'(color), 0);
    check("rst_rom", int'(rom_addr) + int'(rom_sel), 0);
    resetn = 1'b1;

    // Basic tile
    go_a(10, 20, 2, 1'b0);
    watch_a(400, 1, 1'b0, -1);
    check("basic_plots", n_plot, 144);
    check("basic_first_cyc", first_cyc, k + 2);
    check("basic_first_x", fx, 10);
    check("basic_first_y", fy, 20);
    check("basic_second_y", sx * 1000 + sy, 10 * 1000 + 21);
    check("basic_last", lx * 1000 + ly, 21 * 1000 + 31);
    check("basic_color", col_err, 0);
    check("basic_done_cyc", done_cyc, k + 146);
    check("basic_rom_sel", rom_sel, 2);
    @(negedge clock);
    check("basic_busy_after", busy, 0);
    check("basic_done_pulse", done, 0);

    // Corner mask
    go_a(10, 20, 2, 1'b1);
    watch_a(400, 1, 1'b0, -1);
    check("mask_plots", n_plot, 140);
    check("mask_corners", corner_err, 0);
    check("mask_first_y", fy, 21);
    check("mask_done_cyc", done_cyc, k + 146);
    check("mask_color", col_err, 0);

    // Screen-edge clipping
    @(negedge clock);
    go_a(155, 115, 3, 1'b0);
    watch_a(400, 1, 1'b0, -1);
    check("clip_plots", n_plot, 25);
    check("clip_offscreen", clip_err, 0);
    check("clip_last", lx * 1000 + ly, 159 * 1000 + 119);
    check("clip_done_cyc", done_cyc, k + 146);

    // Reset in the middle of a tile
    @(negedge clock);
    go_a(40, 50, 1, 1'b0);
    n_plot = 0;
    for (int i = 0; i < 200 && n_plot < 50; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (plot) n_plot++;
    end
    check("midrst_reached", n_plot, 50);
    resetn = 1'b0;
    #1;
    check("midrst_plot", plot, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clock);
    resetn = 1'b1;
    go_a(0, 0, 0, 1'b0);
    watch_a(400, 1, 1'b0, -1);
    check("fresh_plots", n_plot, 144);
    check("fresh_first", fx * 1000 + fy, 0);
    check("fresh_last", lx * 1000 + ly, 11 * 1000 + 11);
    check("fresh_done_cyc", done_cyc, k + 146);

    // start held high; x_in changes mid-tile and only affects the next tile
    @(negedge clock);
    go_a(10, 20, 2, 1'b0);
    watch_a(800, 2, 1'b1, 60);
    check("hold_dones", n_done, 2);
    check("hold_plots", n_plot, 288);
    check("hold_anchor", anc_err, 0);
    check("hold_color", col_err, 0);
    check("hold_last_x", lx, 99 + 11);
    start = 1'b0;
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;

    // 6x6 tile with three-cycle ROM latency
    @(negedge clock);
    b_start = 1'b1;
    kb = cyc + 1;
    bn = 0; bfirst = -1; bdone = -1; bcol = 0; bfx = -1; bfy = -1; blx = -1; bly = -1;
    for (int i = 0; i < 120 && bdone < 0; i++) begin
      @(negedge clock);
      b_start = 1'b0;
      if (b_plot) begin
        bn++;
        if (bn == 1) begin bfirst = cyc + 1; bfx = int'(b_x_out); bfy = int'(b_y_out); end
        blx = int'(b_x_out); bly = int'(b_y_out);
        idx = (int'(b_x_out) - 30) * 6 + (int'(b_y_out) - 40);
        if (int'(b_color) != idx % 8) bcol++;
      end
      if (b_done) bdone = cyc + 1;
    end
    check("lat3_plots", bn, 36);
    check("lat3_first_cyc", bfirst, kb + 4);
    check("lat3_first", bfx * 1000 + bfy, 30 * 1000 + 40);
    check("lat3_last", blx * 1000 + bly, 35 * 1000 + 45);
    check("lat3_color", bcol, 0);
    check("lat3_done_cyc", bdone, kb + 40);
    @(negedge clock);
    check("lat3_busy_after", b_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
